lcd_read_controller: RTL and testbench
======================================

LCD_READ_CONTROLLER -- requirements
Module: lcd_read_controller

Interface
REQ-001 Parameter CLK_DIVIDE, default 16, number of iCLK cycles LCD_EN is held high per read strobe (min 2).
REQ-002 Parameter SETUP_CYC, default 2, number of iCLK cycles RS/RW are stable before LCD_EN rises (min 1).
REQ-003 Parameter HOLD_CYC, default 2, number of iCLK cycles RW stays 1 after LCD_EN falls (min 1).
REQ-004 Parameter MAX_POLL, default 255, busy-flag poll limit (used only when LCD_BUSY_POLL_EN is defined).
REQ-005 iCLK  input  1  clock, rising-edge.
REQ-006 iRST_N  input  1  reset, asynchronous, active-low.
REQ-007 iStart  input  1  level request; accepted only in IDLE.
REQ-008 iRS  input  1  0 = status read (BF + address counter), 1 = DDRAM/CGRAM data read.
REQ-009 oDATA  output  8  last byte sampled from the LCD.
REQ-010 oDone  output  1  one-cycle pulse, oDATA valid from this cycle until the next accept.
REQ-011 oBusy  output  1  high from accept until the cycle after oDone.
REQ-012 oTimeout  output  1  one-cycle pulse coincident with oDone when the poll limit expires.
REQ-013 LCD_DATA  inout  8  LCD bus; this block never drives it (constant high-Z), only samples.
REQ-014 LCD_RW  output  1  1 during a transaction, 0 otherwise.
REQ-015 LCD_EN  output  1  read strobe.
REQ-016 LCD_RS  output  1  registered copy of the latched iRS.

Function
REQ-017 States SHALL be IDLE, SETUP, STROBE, HOLD, DONE, plus POLL_CHK when LCD_BUSY_POLL_EN is defined.
REQ-018 IDLE with iStart=1 SHALL latch iRS, set LCD_RW=1, LCD_RS=latched iRS, and go to SETUP on the next edge.
REQ-019 SETUP SHALL last SETUP_CYC cycles with LCD_EN=0, then go to STROBE.
REQ-020 STROBE SHALL hold LCD_EN=1 for exactly CLK_DIVIDE cycles and SHALL register LCD_DATA into oDATA on the last STROBE cycle.
REQ-021 HOLD SHALL last HOLD_CYC cycles with LCD_EN=0 and LCD_RW=1, then go to DONE.
REQ-022 DONE SHALL pulse oDone for one cycle, drop LCD_RW to 0, and return to IDLE.
REQ-023 Accept-to-oDone latency SHALL be 1+SETUP_CYC+CLK_DIVIDE+HOLD_CYC cycles for a single strobe.
REQ-024 iStart and iRS changes outside IDLE SHALL be ignored; iStart held high SHALL start a new transaction on the cycle after DONE.
REQ-025 Timing counter widths SHALL be $clog2 of the largest parameter plus 1; counters SHALL NOT wrap.

Reset
REQ-026 Asserting iRST_N=0 SHALL asynchronously force IDLE, LCD_EN=0, LCD_RW=0, LCD_RS=0, oDATA=8'h00, oDone=0, oBusy=0, oTimeout=0, and clear all counters, including mid-STROBE.

Configuration
REQ-027 With LCD_BUSY_POLL_EN defined, an iRS=1 request SHALL first perform status strobes (RS=0); in POLL_CHK, a sampled bit 7 of 1 SHALL repeat the status strobe, and a sampled bit 7 of 0 SHALL switch RS to 1 and perform the data strobe.
REQ-028 With LCD_BUSY_POLL_EN defined, after MAX_POLL busy status reads the block SHALL go to DONE with oTimeout=1 and oDATA holding the last status byte.
REQ-029 Without LCD_BUSY_POLL_EN, no polling logic and no POLL_CHK state SHALL exist, and oTimeout SHALL be tied to 0.

Structure
REQ-030 Shared package lcd_pkg SHALL hold the state enum, BF_BIT=7, the AC field mask 7'h7F, and the default timing constants.
REQ-031 One sub-module, lcd_strobe_timer, SHALL generate the SETUP/STROBE/HOLD phase counts and phase-end flags.

Verification
REQ-032 Status read with iRS=0 and the LCD model driving 8'h25 -> oDATA=8'h25 and oDone exactly 21 cycles after accept with default parameters.
REQ-033 Data read with iRS=1 and the model driving 8'h41 -> LCD_RS=1 throughout, LCD_EN high for exactly 16 cycles, and oDATA=8'h41.
REQ-034 iRST_N pulsed low at STROBE cycle 5 -> LCD_EN and LCD_RW are 0 in the same cycle, and after release the block is in IDLE with oBusy=0.
REQ-035 iStart held high for 3 transactions -> three oDone pulses spaced 22 cycles apart, with LCD_RW dropping to 0 for one cycle between them.
REQ-036 LCD_BUSY_POLL_EN defined, model returns BF=1 for 3 status reads and then 8'h0A, data 8'h33 -> 4 status strobes, 1 data strobe, oDATA=8'h33, oTimeout=0.
REQ-037 LCD_BUSY_POLL_EN defined with MAX_POLL=4 and BF stuck at 1 -> exactly 4 strobes and oDone coincident with oTimeout.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD read controller.
// The LCD_BUSY_POLL_EN macro adds the POLL_CHK state used for busy-flag polling.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE
`ifdef LCD_BUSY_POLL_EN
    , ST_POLL_CHK
`endif
  } lcd_state_e;

  localparam int unsigned BF_BIT  = 7;
  localparam logic [6:0]  AC_MASK = 7'h7F;

  localparam int unsigned DEF_CLK_DIVIDE = 16;
  localparam int unsigned DEF_SETUP_CYC  = 2;
  localparam int unsigned DEF_HOLD_CYC   = 2;
  localparam int unsigned DEF_MAX_POLL   = 255;

  // One width serves every timing/poll counter so none of them can wrap.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/lcd_strobe_timer.sv
// Phase counter for SETUP/STROBE/HOLD; raises the matching end flag on the
// final cycle of each phase and restarts from zero on every phase change.
module lcd_strobe_timer
  import lcd_pkg::*;
#(
  parameter int unsigned CLK_DIVIDE = DEF_CLK_DIVIDE,
  parameter int unsigned SETUP_CYC  = DEF_SETUP_CYC,
  parameter int unsigned HOLD_CYC   = DEF_HOLD_CYC,
  parameter int unsigned MAX_POLL   = DEF_MAX_POLL
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  lcd_state_e state_i,
  output logic       setup_end_o,
  output logic       strobe_end_o,
  output logic       hold_end_o
);

  localparam int unsigned CW = cnt_width(CLK_DIVIDE, SETUP_CYC, HOLD_CYC, MAX_POLL);
  localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] STROBE_LAST = CW'(CLK_DIVIDE - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_phase;

  always_comb begin
    setup_end_o  = (state_i == ST_SETUP)  && (cnt_q == SETUP_LAST);
    strobe_end_o = (state_i == ST_STROBE) && (cnt_q == STROBE_LAST);
    hold_end_o   = (state_i == ST_HOLD)   && (cnt_q == HOLD_LAST);
    in_phase     = (state_i == ST_SETUP) || (state_i == ST_STROBE) || (state_i == ST_HOLD);
    cnt_d        = cnt_q;
    if (!in_phase || setup_end_o || strobe_end_o || hold_end_o) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/lcd_read_controller.sv
// HD44780-style LCD read sequencer: SETUP -> STROBE -> HOLD -> DONE per request.
// Defining LCD_BUSY_POLL_EN makes data reads poll the busy flag first (POLL_CHK).
module lcd_read_controller
  import lcd_pkg::*;
#(
  parameter int unsigned CLK_DIVIDE = DEF_CLK_DIVIDE,
  parameter int unsigned SETUP_CYC  = DEF_SETUP_CYC,
  parameter int unsigned HOLD_CYC   = DEF_HOLD_CYC,
  parameter int unsigned MAX_POLL   = DEF_MAX_POLL
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iStart,
  input  logic       iRS,
  output logic [7:0] oDATA,
  output logic       oDone,
  output logic       oBusy,
  output logic       oTimeout,
  inout  logic [7:0] LCD_DATA,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS
);

  lcd_state_e state_q;
  logic       setup_end, strobe_end, hold_end;

  assign LCD_DATA = 'z;

  lcd_strobe_timer #(
    .CLK_DIVIDE (CLK_DIVIDE),
    .SETUP_CYC  (SETUP_CYC),
    .HOLD_CYC   (HOLD_CYC),
    .MAX_POLL   (MAX_POLL)
  ) u_timer (
    .iCLK         (iCLK),
    .iRST_N       (iRST_N),
    .state_i      (state_q),
    .setup_end_o  (setup_end),
    .strobe_end_o (strobe_end),
    .hold_end_o   (hold_end)
  );

`ifdef LCD_BUSY_POLL_EN
  localparam int unsigned CW = cnt_width(CLK_DIVIDE, SETUP_CYC, HOLD_CYC, MAX_POLL);
  localparam logic [CW-1:0] POLL_LAST = CW'(MAX_POLL - 1);

  logic          rs_q;
  logic [CW-1:0] poll_cnt_q;
  logic          timeout_q;

  assign oTimeout = timeout_q;
`else
  assign oTimeout = 1'b0;
`endif

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= ST_IDLE;
      LCD_EN  <= 1'b0;
      LCD_RW  <= 1'b0;
      LCD_RS  <= 1'b0;
      oDATA   <= '0;
      oDone   <= 1'b0;
      oBusy   <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
      rs_q       <= 1'b0;
      poll_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      oDone <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
      timeout_q <= 1'b0;
`endif
      unique case (state_q)
        ST_IDLE: begin
          if (iStart) begin
            LCD_RW  <= 1'b1;
            oBusy   <= 1'b1;
            state_q <= ST_SETUP;
`ifdef LCD_BUSY_POLL_EN
            // Every request opens with a status strobe; RS rises only once BF clears.
            rs_q       <= iRS;
            LCD_RS     <= 1'b0;
            poll_cnt_q <= '0;
`else
            LCD_RS     <= iRS;
`endif
          end
        end
        ST_SETUP: begin
          if (setup_end) begin
            LCD_EN  <= 1'b1;
            state_q <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          if (strobe_end) begin
            LCD_EN  <= 1'b0;
            oDATA   <= LCD_DATA;
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (hold_end) begin
`ifdef LCD_BUSY_POLL_EN
            if (rs_q && !LCD_RS) begin
              state_q <= ST_POLL_CHK;
            end else begin
              oDone   <= 1'b1;
              state_q <= ST_DONE;
            end
`else
            oDone   <= 1'b1;
            state_q <= ST_DONE;
`endif
          end
        end
`ifdef LCD_BUSY_POLL_EN
        ST_POLL_CHK: begin
          if (oDATA[BF_BIT]) begin
            if (poll_cnt_q == POLL_LAST) begin
              oDone     <= 1'b1;
              timeout_q <= 1'b1;
              state_q   <= ST_DONE;
            end else begin
              poll_cnt_q <= poll_cnt_q + 1'b1;
              state_q    <= ST_SETUP;
            end
          end else begin
            LCD_RS  <= 1'b1;
            state_q <= ST_SETUP;
          end
        end
`endif
        ST_DONE: begin
          LCD_RW  <= 1'b0;
          oBusy   <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_read_controller.sv
// Self-checking bench for lcd_read_controller with a behavioural LCD bus model.
// Polling scenarios are built only when LCD_BUSY_POLL_EN is defined.
module tb_lcd_read_controller;

  localparam int unsigned CD  = 16;
  localparam int unsigned SU  = 2;
  localparam int unsigned HD  = 2;
  localparam int unsigned TXN = SU + CD + HD;
`ifdef LCD_BUSY_POLL_EN
  localparam int unsigned POLL = 1;
  localparam int unsigned MP   = 4;
`else
  localparam int unsigned POLL = 0;
  localparam int unsigned MP   = 255;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       rs = 1'b0;
  wire  [7:0] lcd_data;
  logic [7:0] odata;
  logic       done, busy, tmo, rw, en, lrs;

  logic [7:0]  status_byte = 8'h00;
  logic [7:0]  data_byte = 8'h00;
  int unsigned busy_n = 0;
  int unsigned st_base = 0;
  int unsigned st_strobes = 0;
  int unsigned dt_strobes = 0;
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  lcd_read_controller #(
    .CLK_DIVIDE (CD),
    .SETUP_CYC  (SU),
    .HOLD_CYC   (HD),
    .MAX_POLL   (MP)
  ) dut (
    .iCLK     (clk),
    .iRST_N   (rst_n),
    .iStart   (start),
    .iRS      (rs),
    .oDATA    (odata),
    .oDone    (done),
    .oBusy    (busy),
    .oTimeout (tmo),
    .LCD_DATA (lcd_data),
    .LCD_RW   (rw),
    .LCD_EN   (en),
    .LCD_RS   (lrs)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge en) begin
    if (lrs) dt_strobes <= dt_strobes + 1;
    else     st_strobes <= st_strobes + 1;
  end

  // LCD model: data register when RS=1, else status with BF forced for the first busy_n reads.
  assign lcd_data = lrs ? data_byte
                  : (((st_strobes - st_base) <= busy_n) ? (status_byte | 8'h80) : status_byte);

  function automatic int unsigned exp_lat(input logic r, input int unsigned bn);
    return 1 + TXN + ((POLL != 0 && r) ? (bn + 1) * (TXN + 1) : 0);
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
  endtask

  task automatic run_txn(input logic r, input logic [7:0] st, input logic [7:0] dt,
                         input int unsigned bn, input bit disturb,
                         output int unsigned lat, output int unsigned en_cyc,
                         output int unsigned rs_bad, output int unsigned busy_cyc,
                         output bit tmo_seen, output bit got);
    int unsigned acc;
    wait_idle();
    status_byte = st; data_byte = dt; busy_n = bn; st_base = st_strobes;
    rs = r; start = 1'b1; acc = cyc;
    lat = 0; en_cyc = 0; rs_bad = 0; busy_cyc = 0; tmo_seen = 1'b0; got = 1'b0;
    for (int k = 1; k < 2000; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (disturb && k == 3) begin rs = ~r; start = 1'b1; end
      if (disturb && k == 8) begin rs = r; start = 1'b0; end
      if (busy) busy_cyc++;
      if (en) begin
        en_cyc++;
        if (lrs !== r) rs_bad++;
      end
      if (done) begin
        lat = cyc - acc; tmo_seen = tmo; got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({en, rw, lrs, done, busy, tmo, odata} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got en=%b rw=%b rs=%b done=%b busy=%b tmo=%b data=%h required all 0",
               en, rw, lrs, done, busy, tmo, odata);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({en, rw, busy, done} !== 4'h0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got en=%b rw=%b busy=%b done=%b required 0", en, rw, busy, done);
    end
  endtask

  task automatic check_txn(input string nm, input logic r, input logic [7:0] st,
                           input logic [7:0] dt, input bit disturb);
    int unsigned lat, en_cyc, rs_bad, busy_cyc;
    bit          t, got;
    logic [7:0]  exp_d;
    exp_d = r ? dt : st;
    run_txn(r, st, dt, 0, disturb, lat, en_cyc, rs_bad, busy_cyc, t, got);
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL %s_done: no oDone within bound", nm); end
    n_checks++;
    if (lat !== exp_lat(r, 0)) begin
      n_fail++; $display("FAIL %s_latency: got %0d required %0d", nm, lat, exp_lat(r, 0));
    end
    n_checks++;
    if (odata !== exp_d) begin n_fail++; $display("FAIL %s_data: got %h required %h", nm, odata, exp_d); end
    n_checks++;
    if (en_cyc !== CD * ((POLL != 0 && r) ? 2 : 1)) begin
      n_fail++; $display("FAIL %s_en_width: got %0d required %0d", nm, en_cyc, CD * ((POLL != 0 && r) ? 2 : 1));
    end
    n_checks++;
    if (rs_bad !== ((POLL != 0 && r) ? CD : 0)) begin
      n_fail++; $display("FAIL %s_rs_stable: got %0d off cycles required %0d", nm, rs_bad, (POLL != 0 && r) ? CD : 0);
    end
    n_checks++;
    if (busy_cyc !== exp_lat(r, 0) || t !== 1'b0) begin
      n_fail++; $display("FAIL %s_busy_tmo: got busy=%0d tmo=%b required busy=%0d tmo=0", nm, busy_cyc, t, exp_lat(r, 0));
    end
  endtask

  task automatic test_status_read();
    check_txn("status", 1'b0, 8'h25, 8'h99, 1'b0);
  endtask

  task automatic test_data_read();
    check_txn("data", 1'b1, 8'h07, 8'h41, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      check_txn("random", 1'($urandom), 8'($urandom) & 8'h7F, 8'($urandom), 1'b0);
    end
  endtask

  task automatic test_ignore_inputs();
    check_txn("ignore", 1'b0, 8'h5C, 8'hA3, 1'b1);
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_no_restart: got busy=%b required 0", busy); end
  endtask

  task automatic test_reset_mid_strobe();
    int unsigned hi;
    wait_idle();
    status_byte = 8'h3C; busy_n = 0; st_base = st_strobes;
    rs = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    hi = 0;
    for (int k = 0; k < 100 && hi < 5; k++) begin
      @(negedge clk);
      if (en) hi++;
    end
    n_checks++;
    if (hi !== 5) begin n_fail++; $display("FAIL midreset_reach: got %0d strobe cycles required 5", hi); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({en, rw, busy, odata} !== 11'h0) begin
      n_fail++; $display("FAIL midreset_async: got en=%b rw=%b busy=%b data=%h required 0", en, rw, busy, odata);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({en, rw, busy, done} !== 4'h0) begin
      n_fail++; $display("FAIL midreset_idle: got en=%b rw=%b busy=%b done=%b required 0", en, rw, busy, done);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned d[3];
    int unsigned nd, rw_low, dcyc;
    wait_idle();
    status_byte = 8'($urandom) & 8'h7F; busy_n = 0; st_base = st_strobes;
    rs = 1'b0; start = 1'b1;
    nd = 0; rw_low = 0; dcyc = 0;
    for (int k = 0; k < 200 && nd < 3; k++) begin
      @(negedge clk);
      if (nd >= 1 && !rw) rw_low++;
      if (done) begin
        d[nd] = cyc; nd++; dcyc++;
        if (nd == 3) start = 1'b0;
      end
    end
    n_checks++;
    if (nd !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d pulses required 3", nd); end
    n_checks++;
    if (nd == 3 && (d[1] - d[0] !== 22 || d[2] - d[1] !== 22)) begin
      n_fail++; $display("FAIL b2b_spacing: got %0d,%0d required 22,22", d[1] - d[0], d[2] - d[1]);
    end
    n_checks++;
    if (rw_low !== 2) begin n_fail++; $display("FAIL b2b_rw_gap: got %0d low cycles required 2", rw_low); end
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || odata !== status_byte) begin
      n_fail++; $display("FAIL b2b_end: got busy=%b data=%h required busy=0 data=%h", busy, odata, status_byte);
    end
  endtask

`ifdef LCD_BUSY_POLL_EN
  task automatic test_poll(input int unsigned bn, input logic [7:0] st, input logic [7:0] dt);
    int unsigned lat, en_cyc, rs_bad, busy_cyc, s0, d0, exp_s, exp_d_n, exp_l;
    bit          t, got, exp_t;
    logic [7:0]  exp_d;
    exp_t   = (bn >= MP);
    exp_s   = exp_t ? MP : bn + 1;
    exp_d_n = exp_t ? 0 : 1;
    exp_l   = exp_t ? 1 + MP * (TXN + 1) : exp_lat(1'b1, bn);
    exp_d   = exp_t ? (st | 8'h80) : dt;
    s0 = st_strobes; d0 = dt_strobes;
    run_txn(1'b1, st, dt, bn, 1'b0, lat, en_cyc, rs_bad, busy_cyc, t, got);
    @(negedge clk);
    n_checks++;
    if (st_strobes - s0 !== exp_s || dt_strobes - d0 !== exp_d_n) begin
      n_fail++; $display("FAIL poll_strobes: got status=%0d data=%0d required %0d,%0d",
                         st_strobes - s0, dt_strobes - d0, exp_s, exp_d_n);
    end
    n_checks++;
    if (odata !== exp_d || t !== exp_t || !got) begin
      n_fail++; $display("FAIL poll_result: got data=%h tmo=%b done=%b required data=%h tmo=%b done=1",
                         odata, t, got, exp_d, exp_t);
    end
    n_checks++;
    if (lat !== exp_l) begin n_fail++; $display("FAIL poll_latency: got %0d required %0d", lat, exp_l); end
  endtask
`endif

  initial begin
    test_reset();
    test_status_read();
    test_data_read();
    test_random();
    test_ignore_inputs();
    test_reset_mid_strobe();
    test_back_to_back();
`ifdef LCD_BUSY_POLL_EN
    test_poll(3, 8'h0A, 8'h33);
    test_poll(100, 8'h0A, 8'h33);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
